// File: rtl/reg_scoreboard_pkg.sv
// Shared constants and types for the register scoreboard.
// Pulled in by the counter, the interface users and the top.
package reg_scoreboard_pkg;

  localparam int WORD_SIZE   = 32;
  localparam int NUM_REGS    = 4;
  localparam int REG_W       = 2;
  localparam int MAX_PENDING = 3;
  localparam int CNT_W       = 2;

  typedef logic [REG_W-1:0] reg_idx_t;
  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/reg_scoreboard_if.sv
// Issue and writeback bundle between decode/writeback and the scoreboard.
// master drives requests, slave answers with issue_ready.
interface reg_scoreboard_if;
  import reg_scoreboard_pkg::*;

  logic     issue_valid;
  reg_idx_t issue_rs1;
  reg_idx_t issue_rs2;
  logic     issue_use_rs1;
  logic     issue_use_rs2;
  logic     issue_writes;
  reg_idx_t issue_rd;
  logic     issue_ready;
  logic     wb_valid;
  reg_idx_t wb_rd;
  logic     flush;

  modport master (
    output issue_valid, issue_rs1, issue_rs2,
    output issue_use_rs1, issue_use_rs2,
    output issue_writes, issue_rd,
    output wb_valid, wb_rd, flush,
    input  issue_ready
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2,
    input  issue_use_rs1, issue_use_rs2,
    input  issue_writes, issue_rd,
    input  wb_valid, wb_rd, flush,
    output issue_ready
  );

endinterface

// File: rtl/reg_scoreboard_counter.sv
// Pending-write counter for one register.
// Saturates at MAX_PENDING and refuses to go below zero.
module scoreboard_counter
  import reg_scoreboard_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic inc,
  input  logic dec,
  input  logic clr,
  output logic nonzero,
  output logic full,
  output logic underflow
);

  cnt_t cnt;
  logic decOk;

  assign nonzero   = (cnt != '0);
  assign full      = (cnt == cnt_t'(MAX_PENDING));
  assign underflow = dec && !nonzero;
  assign decOk     = dec && nonzero;

  // A dropped (underflowing) decrement lets a same-cycle inc through.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !decOk && !full) begin
      cnt <= cnt + 1'b1;
    end else if (decOk && !inc) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: RAW/WAW hazard tracking between issue and writeback.
// Also counts stall cycles and latches writeback underflow.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  reg_scoreboard_if.slave     sb,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic [15:0]         stall_count,
  output logic                error
);

  logic [NUM_REGS-1:0] nz;
  logic [NUM_REGS-1:0] full;
  logic [NUM_REGS-1:0] uf;
  logic [NUM_REGS-1:0] inc;
  logic [NUM_REGS-1:0] dec;
  logic                fire;
  logic                stall;

  // No writeback bypass: ready looks only at registered counters.
  always_comb begin
    sb.issue_ready = 1'b1;
    if (sb.flush)
      sb.issue_ready = 1'b0;
    if (sb.issue_use_rs1 && nz[sb.issue_rs1])
      sb.issue_ready = 1'b0;
    if (sb.issue_use_rs2 && nz[sb.issue_rs2])
      sb.issue_ready = 1'b0;
    if (sb.issue_writes && full[sb.issue_rd])
      sb.issue_ready = 1'b0;
  end

  assign fire  = sb.issue_valid && sb.issue_ready;
  assign stall = sb.issue_valid && !sb.issue_ready && !sb.flush;

  always_comb begin
    inc = '0;
    dec = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      inc[i] = fire && sb.issue_writes
            && (sb.issue_rd == reg_idx_t'(i));
      dec[i] = sb.wb_valid
            && (sb.wb_rd == reg_idx_t'(i));
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : gCnt
    scoreboard_counter uCnt (
      .clk       (clk),
      .reset_n   (reset_n),
      .inc       (inc[g]),
      .dec       (dec[g]),
      .clr       (sb.flush),
      .nonzero   (nz[g]),
      .full      (full[g]),
      .underflow (uf[g])
    );
  end

  assign busy_mask = nz;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_count <= '0;
      error       <= 1'b0;
    end else begin
      if (stall && stall_count != 16'hFFFF)
        stall_count <= stall_count + 16'd1;
      if (!sb.flush && |uf)
        error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard.
// Reference model predicts each cycle; predictions pass through a queue.
`timescale 1ns/1ps
module tb_reg_scoreboard;
  import reg_scoreboard_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  busy_mask;
  logic [15:0] stall_count;
  logic        error;

  reg_scoreboard_if sbIf ();

  reg_scoreboard dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sb          (sbIf),
    .busy_mask   (busy_mask),
    .stall_count (stall_count),
    .error       (error)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic        rdy;
    logic [3:0]  busy;
    logic [15:0] stall;
    logic        err;
  } exp_t;

  exp_t expQ[$];
  int   mCnt[4];
  int   mStall = 0;
  bit   mErr = 1'b0;
  int   checks = 0;
  int   errors = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] mBusy();
    logic [3:0] b;
    for (int i = 0; i < 4; i++) b[i] = (mCnt[i] != 0);
    return b;
  endfunction

  task automatic mReset();
    for (int i = 0; i < 4; i++) mCnt[i] = 0;
    mStall = 0;
    mErr   = 1'b0;
  endtask

  // One clock cycle: drive, predict, compare, then advance the model.
  task automatic cyc(bit v, bit [1:0] rs1, bit u1, bit [1:0] rs2, bit u2,
                     bit wr, bit [1:0] rd, bit wv, bit [1:0] wrd, bit fl,
                     bit chk = 1'b1);
    exp_t e;
    bit   rdy;
    int   d[4];
    sbIf.issue_valid   = v;
    sbIf.issue_rs1     = rs1;
    sbIf.issue_use_rs1 = u1;
    sbIf.issue_rs2     = rs2;
    sbIf.issue_use_rs2 = u2;
    sbIf.issue_writes  = wr;
    sbIf.issue_rd      = rd;
    sbIf.wb_valid      = wv;
    sbIf.wb_rd         = wrd;
    sbIf.flush         = fl;
    rdy = !fl && !(u1 && mCnt[rs1] != 0) && !(u2 && mCnt[rs2] != 0)
       && !(wr && mCnt[rd] == MAX_PENDING);
    if (chk) begin
      expQ.push_back('{rdy, mBusy(), 16'(mStall), mErr});
      #2;
      e = expQ.pop_front();
      check("issue_ready", 32'(sbIf.issue_ready), 32'(e.rdy));
      check("busy_mask", 32'(busy_mask), 32'(e.busy));
      check("stall_count", 32'(stall_count), 32'(e.stall));
      check("error", 32'(error), 32'(e.err));
    end
    @(posedge clk);
    if (fl) begin
      for (int i = 0; i < 4; i++) mCnt[i] = 0;
    end else begin
      for (int i = 0; i < 4; i++) d[i] = 0;
      if (v && rdy && wr) d[rd]++;
      if (wv) begin
        if (mCnt[wrd] == 0) mErr = 1'b1;
        else d[wrd]--;
      end
      for (int i = 0; i < 4; i++) mCnt[i] += d[i];
    end
    if (v && !rdy && !fl && mStall < 65535) mStall++;
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    sbIf.issue_valid   = 1'b0;
    sbIf.issue_rs1     = '0;
    sbIf.issue_rs2     = '0;
    sbIf.issue_use_rs1 = 1'b0;
    sbIf.issue_use_rs2 = 1'b0;
    sbIf.issue_writes  = 1'b0;
    sbIf.issue_rd      = '0;
    sbIf.wb_valid      = 1'b0;
    sbIf.wb_rd         = '0;
    sbIf.flush         = 1'b0;
    mReset();
    #5;
    check("rst_busy", 32'(busy_mask), 32'h0);
    check("rst_stall", 32'(stall_count), 32'h0);
    check("rst_error", 32'(error), 32'h0);
    check("rst_ready", 32'(sbIf.issue_ready), 32'h1);
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // RAW: write r1, reader of r1 stalls until the cycle after wb r1
    cyc(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    check("raw_busy", 32'(busy_mask), 32'b0010);
    cyc(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0, 0, 1, 1, 0);
    cyc(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    check("raw_stall", 32'(stall_count), 32'd3);

    // WAW: three writes to r2, fourth blocked until a wb frees a slot
    repeat (3) cyc(1, 0, 0, 0, 0, 1, 2, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 2, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 2, 1, 2, 0);
    cyc(1, 0, 0, 0, 0, 1, 2, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 1, 2, 0);
    idle();
    check("waw_busy", 32'(busy_mask), 32'h0);

    // Issue and writeback to r3 in the same cycle
    cyc(1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 3, 1, 3, 0);
    check("sim_busy3", 32'(busy_mask[3]), 32'h1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 3, 0);
    idle();

    // Underflow, then underflow alongside an increment
    check("pre_uf_err", 32'(error), 32'h0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle();
    check("uf_err", 32'(error), 32'h1);
    cyc(1, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    check("uf_inc_busy", 32'(busy_mask), 32'b0001);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle();

    // Flush with pending r1/r2 and a stalled reader
    cyc(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 2, 0, 0, 0);
    cyc(1, 1, 1, 2, 1, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 2, 1, 0, 0, 0, 0, 1);
    cyc(1, 1, 1, 2, 1, 0, 0, 0, 0, 0);
    check("flush_busy", 32'(busy_mask), 32'h0);

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      cyc(1'($urandom()), 2'($urandom()), 1'($urandom()),
          2'($urandom()), 1'($urandom()), 1'($urandom()),
          2'($urandom()), 1'($urandom()), 2'($urandom()),
          ($urandom_range(0, 19) == 0));
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle();

    // Stall counter saturation
    cyc(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    for (int n = 0; n < 65600; n++) cyc(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    check("stall_sat", 32'(stall_count), 32'hFFFF);

    // Asynchronous reset in the middle of a cycle
    sbIf.issue_valid = 1'b0;
    sbIf.issue_use_rs1 = 1'b0;
    reset_n = 1'b0;
    #2;
    mReset();
    check("arst_busy", 32'(busy_mask), 32'h0);
    check("arst_stall", 32'(stall_count), 32'h0);
    check("arst_error", 32'(error), 32'h0);
    check("arst_ready", 32'(sbIf.issue_ready), 32'h1);
    #1 reset_n = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    idle();
    check("post_rst_uf", 32'(error), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
